clk_div_gen: RTL and testbench

//  Parametrised multi-channel digital clock generator from one reference clock.

---
 rtl/clk_div_gen_pkg.sv | 17 +
 rtl/clk_div_gen_chan.sv | 64 ++++++
 rtl/clk_div_gen.sv | 86 ++++++++
 tb/tb_clk_div_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {SYNC, SETTLE, LOCKED} state_e;

  localparam int unsigned DIV_MIN = 2;

  // Helpers work on 32-bit values; callers zero-extend and truncate (DIV_W <= 32).
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < DIV_MIN) ? 32'(DIV_MIN) : d;
  endfunction

  function automatic logic [31:0] clamp_phase(input logic [31:0] p, input logic [31:0] d);
    return (p > d - 32'd1) ? d - 32'd1 : p;
  endfunction

endpackage

// File: rtl/clk_div_gen_chan.sv
// One divider channel: programmed ratio/phase, free-running counter, registered wave and strobe.
module clk_div_chan
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             sync,
  output logic             outclk,
  output logic             stb
);

  logic [DIV_W-1:0] div_q, div_d, phase_q, phase_d, cnt_q, cnt_d;
  logic             outclk_q, outclk_d, stb_q, stb_d;
  logic [31:0]      div_c;

  always_comb begin
    div_c    = clamp_div(32'(wr_div));
    div_d    = div_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    outclk_d = outclk_q;
    stb_d    = stb_q;
    if (wr_en) begin
      div_d   = DIV_W'(div_c);
      phase_d = DIV_W'(clamp_phase(32'(wr_phase), div_c));
    end
    if (sync) begin
      // Phase is loaded as the counter start so all channels restart together.
      cnt_d    = phase_q;
      outclk_d = 1'b0;
      stb_d    = 1'b0;
    end else begin
      cnt_d    = (cnt_q == div_q - 1'b1) ? '0 : cnt_q + 1'b1;
      outclk_d = (cnt_q < (div_q >> 1));
      stb_d    = (cnt_q == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= DIV_W'(DEFAULT_DIV);
      phase_q  <= '0;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      stb_q    <= stb_d;
    end
  end

  assign outclk = outclk_q;
  assign stb    = stb_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel refclk divider with config handshake and lock/realign sequencing.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter  int NUM_CLOCKS  = 4,
  parameter  int DIV_W       = 16,
  parameter  int DEFAULT_DIV = 12,
  parameter  int LOCK_CYCLES = 256,
  localparam int CHW         = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHW-1:0]        cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_stb,
  output logic                  locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  state_e          state_q, state_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic            sync, xfer, chan_ok;
  logic [NUM_CLOCKS-1:0] wr_en;

  assign xfer    = cfg_valid && (state_q == LOCKED);
  assign chan_ok = (32'(cfg_chan) < 32'(NUM_CLOCKS));

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    sync       = 1'b0;
    case (state_q)
      SYNC: begin
        sync       = 1'b1;
        lock_cnt_d = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) state_d = LOCKED;
        else lock_cnt_d = lock_cnt_q + 1'b1;
      end
      LOCKED: begin
        // Out-of-range channel writes are swallowed without disturbing lock.
        if (xfer && chan_ok) state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign cfg_ready = locked;

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    assign wr_en[i] = xfer && chan_ok && (cfg_chan == CHW'(i));

    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (refclk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_div  (cfg_div),
      .wr_phase(cfg_phase),
      .sync    (sync),
      .outclk  (outclk[i]),
      .stb     (outclk_stb[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen; five channels so a 3-bit select can address channel 7.
module tb_clk_div_gen;

  localparam int NC   = 5;
  localparam int LOCK = 256;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, locked;
  logic [2:0]    cfg_chan = '0;
  logic [15:0]   cfg_div = '0, cfg_phase = '0;
  logic [NC-1:0] outclk, outclk_stb;

  int tests = 0;
  int fails = 0;
  int fj[NC];

  clk_div_gen #(
    .NUM_CLOCKS (NC),
    .DIV_W      (16),
    .DEFAULT_DIV(12),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .outclk_stb(outclk_stb),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples since the current negedge with locked low; stops on the first locked sample.
  task automatic wait_lock(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 2000) begin
      n++;
      @(negedge refclk);
    end
  endtask

  task automatic cfg_write(input int ch, input int dv, input int ph);
    int w;
    w = 0;
    while (cfg_ready !== 1'b1 && w < 2000) begin
      w++;
      @(negedge refclk);
    end
    cfg_chan  = 3'(ch);
    cfg_div   = 16'(dv);
    cfg_phase = 16'(ph);
    cfg_valid = 1'b1;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic meas(input int ch, output int hi, output int lo, output int gap);
    int b;
    b = 0;
    while (outclk_stb[ch] !== 1'b1 && b < 100) begin b++; @(negedge refclk); end
    gap = 0;
    do begin @(negedge refclk); gap++; end while (outclk_stb[ch] !== 1'b1 && gap < 100);
    b = 0;
    while (outclk[ch] !== 1'b0 && b < 100) begin b++; @(negedge refclk); end
    b = 0;
    while (outclk[ch] !== 1'b1 && b < 100) begin b++; @(negedge refclk); end
    hi = 0;
    while (outclk[ch] === 1'b1 && hi < 100) begin hi++; @(negedge refclk); end
    lo = 0;
    while (outclk[ch] === 1'b0 && lo < 100) begin lo++; @(negedge refclk); end
  endtask

  // Offset (in samples) of each channel's first strobe, counted from the current sample.
  task automatic first_stbs();
    for (int c = 0; c < NC; c++) fj[c] = -1;
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NC; c++)
        if (fj[c] < 0 && outclk_stb[c] === 1'b1) fj[c] = k;
      @(negedge refclk);
    end
  endtask

  // Counter after the realign edge is phase, so at the first locked sample the
  // strobe shows after j more samples where (p + LOCK - 1 + j) mod d == 0.
  function automatic int exp_j(input int d, input int p);
    return (d - ((p + LOCK - 1) % d)) % d;
  endfunction

  initial begin
    int n, hi, lo, gap, ok;

    repeat (3) @(negedge refclk);
    check("rst_outclk", 32'(outclk), 0);
    check("rst_stb", 32'(outclk_stb), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ready", 32'(cfg_ready), 0);

    rst = 1'b0;
    wait_lock(n);
    check("init_lock_len", n, LOCK + 1);
    meas(0, hi, lo, gap);
    check("ch0_period", gap, 12);
    check("ch0_high", hi, 6);
    check("ch0_low", lo, 6);

    cfg_write(1, 5, 0);
    wait_lock(n);
    check("ch1_relock_len", n, LOCK + 1);
    meas(1, hi, lo, gap);
    check("ch1_div5_period", gap, 5);
    check("ch1_div5_high", hi, 2);
    check("ch1_div5_low", lo, 3);

    cfg_write(3, 8, 0);
    wait_lock(n);
    cfg_write(2, 8, 3);
    wait_lock(n);
    check("ch2_relock_len", n, LOCK + 1);
    first_stbs();
    check("align_ch3", fj[3], exp_j(8, 0));
    check("align_ch2", fj[2], exp_j(8, 3));
    check("ch3_to_ch2_gap", fj[2] - fj[3], 5);
    check("align_ch0", fj[0], exp_j(12, 0));
    check("align_ch1", fj[1], exp_j(5, 0));

    cfg_write(1, 0, 0);
    wait_lock(n);
    meas(1, hi, lo, gap);
    check("div0_period", gap, 2);
    check("div0_high", hi, 1);
    check("div0_low", lo, 1);

    cfg_write(1, 1, 0);
    wait_lock(n);
    meas(1, hi, lo, gap);
    check("div1_period", gap, 2);
    check("div1_high", hi, 1);

    cfg_write(1, 10, 40);
    wait_lock(n);
    first_stbs();
    check("phase_clamp_ch1", fj[1], exp_j(10, 9));

    n = 0;
    while (outclk_stb[0] !== 1'b1 && n < 100) begin n++; @(negedge refclk); end
    check("oor_ready", 32'(cfg_ready), 1);
    cfg_chan  = 3'd7;
    cfg_div   = 16'd3;
    cfg_phase = 16'd1;
    cfg_valid = 1'b1;
    gap = 0;
    ok  = 1;
    do begin
      @(negedge refclk);
      gap++;
      cfg_valid = 1'b0;
      if (locked !== 1'b1) ok = 0;
    end while (outclk_stb[0] !== 1'b1 && gap < 100);
    check("oor_locked_held", ok, 1);
    check("oor_ch0_period", gap, 12);
    meas(1, hi, lo, gap);
    check("oor_ch1_period", gap, 10);

    cfg_write(1, 5, 2);
    repeat (50) @(negedge refclk);
    check("settle_unlocked", 32'(locked), 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_outclk", 32'(outclk), 0);
    check("midrst_stb", 32'(outclk_stb), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_ready", 32'(cfg_ready), 0);
    @(negedge refclk);
    rst = 1'b0;
    wait_lock(n);
    check("rst_relock_len", n, LOCK + 1);
    first_stbs();
    check("default_phase_ch1", fj[1], exp_j(12, 0));
    check("default_phase_ch2", fj[2], exp_j(12, 0));
    meas(1, hi, lo, gap);
    check("default_ch1_period", gap, 12);
    check("default_ch1_high", hi, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
